// File: rtl/cceip_outbound.sv
// cceip_outbound: engine result stream -> 2-entry skid buffer -> memory writer stream,
// with byte accounting, output-buffer size enforcement and optional CCEIP_OUTBOUND_WATCHDOG_EN idle watchdog.
module cceip_outbound #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic                  ap_clk,
   input  logic                  ap_reset_n,
   input  logic                  outbound_start,
   input  logic [63:0]           output_buffer_size,
   input  logic                  cceip_s_axis_tvalid,
   output logic                  cceip_s_axis_tready,
   input  logic [DATA_WIDTH-1:0] cceip_s_axis_tdata,
   input  logic                  cceip_s_axis_tlast,
   output logic                  mm_m_axis_tvalid,
   input  logic                  mm_m_axis_tready,
   output logic [DATA_WIDTH-1:0] mm_m_axis_tdata,
   output logic                  outbound_done,
   output logic [63:0]           output_data_size,
   output logic                  output_overflow,
   output logic                  output_timeout
);

   localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
   localparam logic [64:0] BEAT_BYTES     = 65'(BYTES_PER_BEAT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
      $error("cceip_outbound: DATA_WIDTH must be a non-zero multiple of 8 and TIMEOUT_CYCLES non-zero");
   end

   logic [1:0]            state_q, state_d;
   logic [63:0]           size_lim_q, size_lim_d;
   logic [63:0]           fwd_bytes_q, fwd_bytes_d;
   logic [63:0]           data_size_q, data_size_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
   logic                  s_tready_q, s_tready_d;
   logic                  m_tvalid_q, m_tvalid_d;

   logic                  start_c;
   logic                  accept_c;
   logic                  pop_c;
   logic                  push_c;
   logic                  fits_c;
   logic [64:0]           fwd_sum_c;
   logic [64:0]           size_sum_c;
   logic                  wd_expire_c;

   // Handshakes are qualified by registered ready/valid only.
   assign start_c    = outbound_start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign accept_c   = cceip_s_axis_tvalid && s_tready_q;
   assign pop_c      = m_tvalid_q && mm_m_axis_tready;
   assign fwd_sum_c  = {1'b0, fwd_bytes_q} + BEAT_BYTES;
   assign size_sum_c = {1'b0, data_size_q} + BEAT_BYTES;
   assign fits_c     = fwd_sum_c <= {1'b0, size_lim_q};
   assign push_c     = accept_c && fits_c;

   // Control FSM and byte accounting.
   always_comb begin
      state_d     = state_q;
      size_lim_d  = size_lim_q;
      fwd_bytes_d = fwd_bytes_q;
      data_size_d = data_size_q;
      overflow_d  = overflow_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_c) begin
               state_d     = ST_RUN;
               size_lim_d  = output_buffer_size;
               fwd_bytes_d = 64'd0;
               data_size_d = 64'd0;
               overflow_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept_c) begin
               data_size_d = size_sum_c[64] ? {64{1'b1}} : size_sum_c[63:0];
               if (fits_c) begin
                  fwd_bytes_d = fwd_sum_c[63:0];
               end else begin
                  overflow_d = 1'b1;
               end
               if (cceip_s_axis_tlast) begin
                  state_d = ST_DRAIN;
               end
            end else if (wd_expire_c) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 2'd0) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      done_d = (state_d == ST_DONE);
   end

   // Two-entry skid buffer; ent0 is always the head.
   always_comb begin
      cnt_d  = cnt_q;
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      case (cnt_q)
         2'd0: begin
            if (push_c) begin
               ent0_d = cceip_s_axis_tdata;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push_c && pop_c) begin
               ent0_d = cceip_s_axis_tdata;
            end else if (push_c) begin
               ent1_d = cceip_s_axis_tdata;
               cnt_d  = 2'd2;
            end else if (pop_c) begin
               cnt_d = 2'd0;
            end
         end
         2'd2: begin
            if (pop_c) begin
               ent0_d = ent1_q;
               cnt_d  = 2'd1;
            end
         end
         default: cnt_d = 2'd0;
      endcase
      s_tready_d = (state_d == ST_RUN) && (cnt_d != 2'd2);
      m_tvalid_d = (cnt_d != 2'd0);
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_reset_n) begin
         state_q     <= ST_IDLE;
         size_lim_q  <= 64'd0;
         fwd_bytes_q <= 64'd0;
         data_size_q <= 64'd0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= 2'd0;
         ent0_q      <= '0;
         ent1_q      <= '0;
         s_tready_q  <= 1'b0;
         m_tvalid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_lim_q  <= size_lim_d;
         fwd_bytes_q <= fwd_bytes_d;
         data_size_q <= data_size_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
         s_tready_q  <= s_tready_d;
         m_tvalid_q  <= m_tvalid_d;
      end
   end

`ifdef CCEIP_OUTBOUND_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;

   // Idle-cycle watchdog; an accepted beat (including tlast) wins over expiry.
   always_comb begin
      wd_d        = wd_q;
      timeout_d   = timeout_q;
      wd_expire_c = 1'b0;
      if (start_c) begin
         wd_d      = '0;
         timeout_d = 1'b0;
      end else if (state_q == ST_RUN) begin
         if (accept_c) begin
            wd_d = '0;
         end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_d        = '0;
            timeout_d   = 1'b1;
            wd_expire_c = 1'b1;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_reset_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign output_timeout = timeout_q;
`else
   assign wd_expire_c    = 1'b0;
   assign output_timeout = 1'b0;
`endif

   assign cceip_s_axis_tready = s_tready_q;
   assign mm_m_axis_tvalid    = m_tvalid_q;
   assign mm_m_axis_tdata     = ent0_q;
   assign outbound_done       = done_q;
   assign output_data_size    = data_size_q;
   assign output_overflow     = overflow_q;

endmodule

// File: tb/tb_cceip_outbound.sv
// Directed bench for cceip_outbound with a scoreboard of forwarded beats.
module tb_cceip_outbound;

   logic        ap_clk = 1'b0;
   logic        ap_reset_n;
   logic        outbound_start;
   logic [63:0] output_buffer_size;
   logic        cceip_s_axis_tvalid;
   logic        cceip_s_axis_tready;
   logic [63:0] cceip_s_axis_tdata;
   logic        cceip_s_axis_tlast;
   logic        mm_m_axis_tvalid;
   logic        mm_m_axis_tready;
   logic [63:0] mm_m_axis_tdata;
   logic        outbound_done;
   logic [63:0] output_data_size;
   logic        output_overflow;
   logic        output_timeout;

   cceip_outbound #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
      .ap_clk              (ap_clk),
      .ap_reset_n          (ap_reset_n),
      .outbound_start      (outbound_start),
      .output_buffer_size  (output_buffer_size),
      .cceip_s_axis_tvalid (cceip_s_axis_tvalid),
      .cceip_s_axis_tready (cceip_s_axis_tready),
      .cceip_s_axis_tdata  (cceip_s_axis_tdata),
      .cceip_s_axis_tlast  (cceip_s_axis_tlast),
      .mm_m_axis_tvalid    (mm_m_axis_tvalid),
      .mm_m_axis_tready    (mm_m_axis_tready),
      .mm_m_axis_tdata     (mm_m_axis_tdata),
      .outbound_done       (outbound_done),
      .output_data_size    (output_data_size),
      .output_overflow     (output_overflow),
      .output_timeout      (output_timeout)
   );

   always #5 ap_clk = ~ap_clk;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [63:0] sb_q[$];
   logic [63:0] m_lim = 64'd0;
   logic [64:0] m_fwd = 65'd0;
   int          pops = 0;
   int          last_pop_cyc = 0;
   int          last_acc_cyc = 0;
   bit          chk_occ = 1'b0;
   bit          rdy_toggle = 1'b0;
   bit          prev_stall = 1'b0;
   logic [63:0] prev_data = 64'd0;

   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sink ready: constant 1 or toggling every cycle.
   initial begin
      mm_m_axis_tready = 1'b1;
      forever begin
         @(posedge ap_clk);
         #1;
         mm_m_axis_tready = rdy_toggle ? ~mm_m_axis_tready : 1'b1;
      end
   end

   // Monitor at negedge: handshakes seen here complete on the next rising edge.
   always @(negedge ap_clk) begin
      if (!ap_reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 64'(mm_m_axis_tvalid), 64'd1);
            chk("stall_data_held", mm_m_axis_tdata, prev_data);
         end
         prev_stall = mm_m_axis_tvalid && !mm_m_axis_tready;
         prev_data  = mm_m_axis_tdata;
         if (chk_occ)
            chk("s_tready_vs_occupancy", 64'(cceip_s_axis_tready), 64'(sb_q.size() != 2));
         if (mm_m_axis_tvalid && mm_m_axis_tready) begin
            tests++;
            assert (sb_q.size() > 0) else begin
               fails++;
               $error("FAIL unexpected_mm_beat: observed data 0x%0h expected no beat", mm_m_axis_tdata);
            end
            if (sb_q.size() > 0) chk("mm_data_order", mm_m_axis_tdata, sb_q.pop_front());
            pops++;
            last_pop_cyc = cyc + 1;
         end
         if (cceip_s_axis_tvalid && cceip_s_axis_tready) begin
            last_acc_cyc = cyc + 1;
            if (m_fwd + 65'd8 <= {1'b0, m_lim}) begin
               sb_q.push_back(cceip_s_axis_tdata);
               m_fwd = m_fwd + 65'd8;
            end
         end
      end
   end

   task automatic start_run(input logic [63:0] size, input bit fresh);
      output_buffer_size = size;
      outbound_start     = 1'b1;
      @(posedge ap_clk);
      #1;
      outbound_start = 1'b0;
      if (fresh) begin
         m_lim   = size;
         m_fwd   = 65'd0;
         pops    = 0;
         chk_occ = 1'b1;
      end
   endtask

   task automatic send(input int n, input logic [63:0] base, input bit with_last, output int stalls);
      bit acc;
      int guard;
      bit all_acc;
      stalls  = 0;
      all_acc = 1'b1;
      for (int i = 0; i < n; i++) begin
         cceip_s_axis_tvalid = 1'b1;
         cceip_s_axis_tdata  = base + 64'(i);
         cceip_s_axis_tlast  = with_last && (i == n - 1);
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 200) begin
            @(negedge ap_clk);
            acc = cceip_s_axis_tready;
            if (!acc) stalls++;
            guard++;
            @(posedge ap_clk);
            #1;
         end
         if (!acc) begin
            all_acc = 1'b0;
            break;
         end
      end
      cceip_s_axis_tvalid = 1'b0;
      cceip_s_axis_tlast  = 1'b0;
      if (with_last) chk_occ = 1'b0;
      tests++;
      assert (all_acc) else begin
         fails++;
         $error("FAIL send_accept: observed beat not accepted within budget expected accept");
      end
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      bit seen;
      seen = 1'b0;
      dcyc = -1;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge ap_clk);
         if (outbound_done) begin
            seen = 1'b1;
            dcyc = cyc;
         end
      end
      tests++;
      assert (seen) else begin
         fails++;
         $error("FAIL done_wait: observed done=0 after %0d cycles expected done=1", budget);
      end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_done"},     64'(outbound_done), 64'd0);
      chk({tag, "_size"},     output_data_size, 64'd0);
      chk({tag, "_overflow"}, 64'(output_overflow), 64'd0);
      chk({tag, "_timeout"},  64'(output_timeout), 64'd0);
      chk({tag, "_mvalid"},   64'(mm_m_axis_tvalid), 64'd0);
      chk({tag, "_mdata"},    mm_m_axis_tdata, 64'd0);
      chk({tag, "_sready"},   64'(cceip_s_axis_tready), 64'd0);
   endtask

   initial begin
      int st;
      int dc;
      ap_reset_n          = 1'b0;
      outbound_start      = 1'b0;
      output_buffer_size  = 64'd0;
      cceip_s_axis_tvalid = 1'b0;
      cceip_s_axis_tdata  = 64'd0;
      cceip_s_axis_tlast  = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1;
      chk_reset_outs("reset");
      ap_reset_n = 1'b1;
      @(posedge ap_clk);
      #1;

      // Large run, both sides always ready.
      start_run(64'd114520, 1'b1);
      send(14315, 64'h1000_0000, 1'b1, st);
      chk("t1_no_bubbles", 64'(st), 64'd0);
      wait_done(100, dc);
      chk("t1_done_latency", 64'(dc), 64'(last_pop_cyc + 1));
      chk("t1_size", output_data_size, 64'd114520);
      chk("t1_overflow", 64'(output_overflow), 64'd0);
      chk("t1_pops", 64'(pops), 64'd14315);
      chk("t1_sb_empty", 64'(sb_q.size()), 64'd0);
      chk("t1_done_level", 64'(outbound_done), 64'd1);

      // Buffer of 16 bytes, 4 beats.
      start_run(64'd16, 1'b1);
      send(4, 64'h2000, 1'b1, st);
      wait_done(50, dc);
      chk("t2_size", output_data_size, 64'd32);
      chk("t2_overflow", 64'(output_overflow), 64'd1);
      chk("t2_pops", 64'(pops), 64'd2);
      chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

      // Sink ready toggling.
      rdy_toggle = 1'b1;
      start_run(64'd800, 1'b1);
      send(100, 64'h3000, 1'b1, st);
      wait_done(100, dc);
      rdy_toggle = 1'b0;
      chk("t3_backpressure_seen", 64'(st != 0), 64'd1);
      chk("t3_size", output_data_size, 64'd800);
      chk("t3_overflow", 64'(output_overflow), 64'd0);
      chk("t3_pops", 64'(pops), 64'd100);
      chk("t3_sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset mid-run, then a fresh short run.
      start_run(64'd800, 1'b1);
      send(10, 64'h4000, 1'b0, st);
      chk_occ    = 1'b0;
      ap_reset_n = 1'b0;
      @(posedge ap_clk);
      #1;
      chk_reset_outs("midrun_reset");
      @(posedge ap_clk);
      #1;
      sb_q.delete();
      ap_reset_n = 1'b1;
      @(posedge ap_clk);
      #1;
      start_run(64'd800, 1'b1);
      send(3, 64'h5000, 1'b1, st);
      wait_done(50, dc);
      chk("t4_size", output_data_size, 64'd24);
      chk("t4_overflow", 64'(output_overflow), 64'd0);
      chk("t4_pops", 64'(pops), 64'd3);
      chk("t4_sb_empty", 64'(sb_q.size()), 64'd0);

      // Start during RUN is ignored (a latched size of 8 would overflow).
      start_run(64'd800, 1'b1);
      send(3, 64'h6000, 1'b0, st);
      start_run(64'd8, 1'b0);
      send(2, 64'h6100, 1'b1, st);
      wait_done(50, dc);
      chk("t5_size", output_data_size, 64'd40);
      chk("t5_overflow", 64'(output_overflow), 64'd0);
      chk("t5_pops", 64'(pops), 64'd5);
      // Start in DONE clears and restarts.
      start_run(64'd800, 1'b1);
      chk("t5_restart_done", 64'(outbound_done), 64'd0);
      chk("t5_restart_size", output_data_size, 64'd0);
      send(1, 64'h7000, 1'b1, st);
      wait_done(50, dc);
      chk("t5_second_size", output_data_size, 64'd8);
      chk("t5_second_pops", 64'(pops), 64'd1);

      // Zero-size buffer discards everything.
      start_run(64'd0, 1'b1);
      send(2, 64'h8000, 1'b1, st);
      wait_done(50, dc);
      chk("t6_size", output_data_size, 64'd16);
      chk("t6_overflow", 64'(output_overflow), 64'd1);
      chk("t6_pops", 64'(pops), 64'd0);

`ifdef CCEIP_OUTBOUND_WATCHDOG_EN
      begin
         int tcyc;
         tcyc = -1;
         start_run(64'd800, 1'b1);
         send(2, 64'h9000, 1'b0, st);
         chk_occ = 1'b0;
         for (int k = 0; k < 100 && tcyc < 0; k++) begin
            @(negedge ap_clk);
            if (output_timeout) tcyc = cyc;
         end
         chk("t7_timeout_cycle", 64'(tcyc), 64'(last_acc_cyc + 16));
         @(posedge ap_clk);
         #1;
         wait_done(50, dc);
         chk("t7_timeout", 64'(output_timeout), 64'd1);
         chk("t7_size", output_data_size, 64'd16);
         chk("t7_pops", 64'(pops), 64'd2);
      end
`else
      chk("timeout_tied_low", 64'(output_timeout), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: observed simulation still running expected completion");
      $fatal(1, "global timeout");
   end

endmodule
